// File: rtl/host_from_breakout_pkg.sv
// host_from_breakout_pkg: shared constants for the breakout link receiver.
// Frame length, expected frame-clock pattern and recovered word bit fields.
package host_from_breakout_pkg;

    localparam int         FRAME_LEN = 5;
    localparam int         WORD_W    = 2 * FRAME_LEN;
    localparam logic [2:0] LAST_SLOT = 3'(FRAME_LEN - 1);

    // Frame-clock pair expected in slot k lives at [2k+1:2k].
    localparam logic [WORD_W-1:0] CLK_PAT = {
        2'b11, 2'b11, 2'b10, 2'b00, 2'b00
    };

    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 8;
    localparam int POW_LSB  = 8;
    localparam int POW_W    = 2;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    function automatic logic [1:0] exp_clk(input logic [2:0] slot);
        logic [1:0] pat;
        pat = 2'b00;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (slot == 3'(k)) pat = CLK_PAT[2*k +: 2];
        end
        return pat;
    endfunction

endpackage

// File: rtl/host_from_breakout_align.sv
// breakout_frame_align: frame-clock tracker (HUNT/CHECK/LOCKED), slot counter
// and saturating lock-loss counter. Ports: i_clk, i_rst, i_clk_pair in;
// o_slot (slot of the current sample), o_frame_done, o_locked, o_err_cnt out.
module breakout_frame_align
    import host_from_breakout_pkg::*;
#(
    parameter int P_LOCK_FRAMES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_clk_pair,
    output logic [2:0]  o_slot,
    output logic        o_frame_done,
    output logic        o_locked,
    output logic [15:0] o_err_cnt
);

    align_state_e state_q, state_d;
    logic [2:0]   slot_q, slot_d;
    logic [3:0]   good_q, good_d;
    logic [15:0]  err_cnt_q, err_cnt_d;
    logic [1:0]   prev_q, prev_d;
    logic         match;
    logic         boundary;
    logic         frame_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_HUNT;
            slot_q    <= 3'd0;
            good_q    <= 4'd0;
            err_cnt_q <= 16'd0;
            prev_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
            prev_q    <= prev_d;
        end
    end

    assign match    = (i_clk_pair == exp_clk(slot_q));
    assign boundary = (i_clk_pair == 2'b00) && (prev_q == 2'b11);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        good_d     = good_q;
        err_cnt_d  = err_cnt_q;
        prev_d     = i_clk_pair;
        frame_done = 1'b0;
        case (state_q)
            ST_HUNT: begin
                // The boundary cycle itself is slot 0, so the next is slot 1.
                if (boundary) begin
                    state_d = ST_CHECK;
                    slot_d  = 3'd1;
                    good_d  = 4'd0;
                end
            end
            ST_CHECK: begin
                if (!match) begin
                    state_d = ST_HUNT;
                    slot_d  = 3'd0;
                end else if (slot_q == LAST_SLOT) begin
                    slot_d = 3'd0;
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == 4'(P_LOCK_FRAMES)) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            ST_LOCKED: begin
                if (!match) begin
                    state_d = ST_HUNT;
                    slot_d  = 3'd0;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end else if (slot_q == LAST_SLOT) begin
                    slot_d     = 3'd0;
                    frame_done = 1'b1;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_HUNT;
                slot_d  = 3'd0;
            end
        endcase
    end

    assign o_slot       = (state_q == ST_HUNT) ? 3'd0 : slot_q;
    assign o_frame_done = frame_done;
    assign o_locked     = (state_q == ST_LOCKED);
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: rtl/host_from_breakout.sv
// host_from_breakout: recovers two 10-bit words per 5-slot DDR frame.
// In: i_clk, i_rst, i_clk_s/i_d0_s/i_d1_s lane pairs. Out: button, port,
// link_pow, valid strobe, locked flag and lock-loss counter.
module host_from_breakout
    import host_from_breakout_pkg::*;
#(
    parameter int P_CLK_INV     = 0,
    parameter int P_LOCK_FRAMES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_clk_s,
    input  logic [1:0]  i_d0_s,
    input  logic [1:0]  i_d1_s,
    output logic [7:0]  o_button,
    output logic [7:0]  o_port,
    output logic [3:0]  o_link_pow,
    output logic        o_valid,
    output logic        o_locked,
    output logic [15:0] o_err_cnt
);

    logic [1:0]        clk_pair;
    logic [2:0]        slot;
    logic              frame_done;
    logic [WORD_W-1:0] asm0_q, asm0_d;
    logic [WORD_W-1:0] asm1_q, asm1_d;
    logic [7:0]        button_q, button_d;
    logic [7:0]        port_q, port_d;
    logic [3:0]        pow_q, pow_d;
    logic              valid_q, valid_d;

    assign clk_pair = (P_CLK_INV != 0) ? ~i_clk_s : i_clk_s;

    breakout_frame_align #(
        .P_LOCK_FRAMES(P_LOCK_FRAMES)
    ) u_align (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_pair  (clk_pair),
        .o_slot      (slot),
        .o_frame_done(frame_done),
        .o_locked    (o_locked),
        .o_err_cnt   (o_err_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            asm0_q   <= '0;
            asm1_q   <= '0;
            button_q <= 8'd0;
            port_q   <= 8'd0;
            pow_q    <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            asm0_q   <= asm0_d;
            asm1_q   <= asm1_d;
            button_q <= button_d;
            port_q   <= port_d;
            pow_q    <= pow_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        asm0_d = asm0_q;
        asm1_d = asm1_q;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (slot == 3'(k)) begin
                asm0_d[2*k +: 2] = i_d0_s;
                asm1_d[2*k +: 2] = i_d1_s;
            end
        end
        button_d = button_q;
        port_d   = port_q;
        pow_d    = pow_q;
        valid_d  = frame_done;
        // Capture from the _d words so the slot-4 sample is included.
        if (frame_done) begin
            button_d = asm0_d[DATA_LSB +: DATA_W];
            port_d   = asm1_d[DATA_LSB +: DATA_W];
            pow_d    = {asm1_d[POW_LSB +: POW_W],
                        asm0_d[POW_LSB +: POW_W]};
        end
    end

    assign o_button   = button_q;
    assign o_port     = port_q;
    assign o_link_pow = pow_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_host_from_breakout.sv
// tb_host_from_breakout: directed frame table, corner sequences and a
// randomized stream checked against a frame-level reference model.
module tb_host_from_breakout;

    localparam int NMAX  = 3000;
    localparam int NRAND = 2800;
    localparam int LOCKN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  clk_s = 2'b00;
    logic [1:0]  d0 = 2'b00;
    logic [1:0]  d1 = 2'b00;
    logic [1:0]  clk_sn;

    logic [7:0]  a_btn, a_port, b_btn, b_port, c_btn, c_port;
    logic [3:0]  a_pow, b_pow, c_pow;
    logic        a_valid, b_valid, c_valid;
    logic        a_lock, b_lock, c_lock;
    logic [15:0] a_err, b_err, c_err;
    logic [37:0] obs_a, obs_b, obs_c;

    int errors = 0;
    int checks = 0;

    logic [1:0] pat [5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};

    logic [1:0]  stim_clk [NMAX];
    logic [1:0]  stim_d0  [NMAX];
    logic [1:0]  stim_d1  [NMAX];
    logic [37:0] exp_m    [2][NMAX];
    int          n_stim;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  p;
        logic [3:0]  w;
        int          cs;
        logic [1:0]  cv;
        logic        el;
        logic        ev;
        logic [15:0] ee;
        logic [7:0]  eb;
        logic [7:0]  ep;
        logic [3:0]  ew;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;
    assign clk_sn = ~clk_s;

    assign obs_a = {a_lock, a_valid, a_err, a_btn, a_port, a_pow};
    assign obs_b = {b_lock, b_valid, b_err, b_btn, b_port, b_pow};
    assign obs_c = {c_lock, c_valid, c_err, c_btn, c_port, c_pow};

    host_from_breakout #(.P_CLK_INV(0), .P_LOCK_FRAMES(LOCKN)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clk_s(clk_s),
        .i_d0_s(d0), .i_d1_s(d1),
        .o_button(a_btn), .o_port(a_port), .o_link_pow(a_pow),
        .o_valid(a_valid), .o_locked(a_lock), .o_err_cnt(a_err)
    );

    host_from_breakout #(.P_CLK_INV(1), .P_LOCK_FRAMES(LOCKN)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clk_s(clk_sn),
        .i_d0_s(d0), .i_d1_s(d1),
        .o_button(b_btn), .o_port(b_port), .o_link_pow(b_pow),
        .o_valid(b_valid), .o_locked(b_lock), .o_err_cnt(b_err)
    );

    host_from_breakout #(.P_CLK_INV(0), .P_LOCK_FRAMES(LOCKN)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_clk_s(clk_sn),
        .i_d0_s(d0), .i_d1_s(d1),
        .o_button(c_btn), .o_port(c_port), .o_link_pow(c_pow),
        .o_valid(c_valid), .o_locked(c_lock), .o_err_cnt(c_err)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] c, input logic [1:0] a0,
                       input logic [1:0] a1);
        clk_s = c;
        d0    = a0;
        d1    = a1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [7:0] p,
                                input logic [3:0] w, input int cs,
                                input logic [1:0] cv, input logic el,
                                input logic ev, input logic [15:0] ee,
                                input logic [7:0] eb, input logic [7:0] ep,
                                input logic [3:0] ew);
        vec_t v;
        v.b = b; v.p = p; v.w = w; v.cs = cs; v.cv = cv;
        v.el = el; v.ev = ev; v.ee = ee;
        v.eb = eb; v.ep = ep; v.ew = ew;
        return v;
    endfunction

    // One frame of five slots; cs selects a slot whose clock pair is
    // replaced by cv (cs < 0 for a clean frame).
    task automatic frame(input logic [7:0] b, input logic [7:0] p,
                         input logic [3:0] w, input int cs,
                         input logic [1:0] cv, input logic ev);
        logic [9:0] w0;
        logic [9:0] w1;
        logic [1:0] c;
        w0 = {w[1:0], b};
        w1 = {w[3:2], p};
        for (int k = 0; k < 5; k++) begin
            c = (k == cs) ? cv : pat[k];
            cyc(c, w0[2*k +: 2], w1[2*k +: 2]);
            chk("valid_a", 64'(a_valid), 64'((k == 4) && ev));
            chk("valid_b", 64'(b_valid), 64'((k == 4) && ev));
            chk("valid_c", 64'(c_valid), 64'd0);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        vec_t v;
        for (int i = lo; i <= hi; i++) begin
            v = tbl[i];
            frame(v.b, v.p, v.w, v.cs, v.cv, v.ev);
            chk("lock_a", 64'(a_lock), 64'(v.el));
            chk("lock_b", 64'(b_lock), 64'(v.el));
            chk("lock_c", 64'(c_lock), 64'd0);
            chk("err_a", 64'(a_err), 64'(v.ee));
            chk("err_b", 64'(b_err), 64'(v.ee));
            chk("data_a", 64'({a_btn, a_port, a_pow}),
                64'({v.eb, v.ep, v.ew}));
            chk("data_b", 64'({b_btn, b_port, b_pow}),
                64'({v.eb, v.ep, v.ew}));
        end
    endtask

    // Frame-level reference: find a boundary, then judge whole 5-cycle
    // frames against the pattern; index c = state after sample c.
    task automatic run_model(input int sel, input int n);
        logic [1:0]  s  [NMAX];
        bit          lk [NMAX];
        bit          vl [NMAX];
        bit          ei [NMAX];
        logic [19:0] fw [NMAX];
        logic [1:0]  pv;
        logic [15:0] err;
        logic [19:0] word;
        int  t, b, f, m, good;
        bit  lockd, stop;
        for (int c = 0; c < n; c++) begin
            s[c]  = (sel != 0) ? ~stim_clk[c] : stim_clk[c];
            lk[c] = 0; vl[c] = 0; ei[c] = 0; fw[c] = '0;
        end
        t = 0;
        stop = 0;
        while (!stop) begin
            b = -1;
            for (int c = t; c < n; c++) begin
                pv = (c > 0) ? s[c-1] : 2'b00;
                if (s[c] == 2'b00 && pv == 2'b11) begin
                    b = c;
                    break;
                end
            end
            if (b < 0) begin
                stop = 1;
            end else begin
                f = b;
                good = 0;
                lockd = 0;
                while (1) begin
                    m = -1;
                    for (int k = 0; k < 5; k++) begin
                        if (f + k >= n) begin
                            m = -2;
                            break;
                        end
                        if (s[f+k] != pat[k]) begin
                            m = f + k;
                            break;
                        end
                    end
                    if (m == -2) begin
                        if (lockd)
                            for (int c = f; c < n; c++) lk[c] = 1;
                        stop = 1;
                        break;
                    end
                    if (m >= 0) begin
                        if (lockd) begin
                            for (int c = f; c < m; c++) lk[c] = 1;
                            ei[m] = 1;
                        end
                        t = m + 1;
                        break;
                    end
                    if (lockd) begin
                        for (int c = f; c < f + 5; c++) lk[c] = 1;
                        vl[f+4] = 1;
                        for (int k = 0; k < 5; k++) begin
                            fw[f+4][2*k +: 2]      = stim_d0[f+k];
                            fw[f+4][10 + 2*k +: 2] = stim_d1[f+k];
                        end
                    end else begin
                        good++;
                        if (good == LOCKN) begin
                            lockd = 1;
                            lk[f+4] = 1;
                        end
                    end
                    f += 5;
                end
            end
        end
        err = 16'd0;
        word = '0;
        for (int c = 0; c < n; c++) begin
            if (ei[c] && err != 16'hFFFF) err = err + 16'd1;
            if (vl[c]) word = fw[c];
            exp_m[sel][c] = {lk[c], vl[c], err, word[7:0],
                             word[17:10], word[19:18], word[9:8]};
        end
    endtask

    task automatic gen_random();
        int g, cs;
        n_stim = 0;
        g = $urandom_range(0, 4);
        for (int i = 0; i < g; i++) begin
            stim_clk[n_stim] = 2'($urandom);
            stim_d0[n_stim]  = 2'($urandom);
            stim_d1[n_stim]  = 2'($urandom);
            n_stim++;
        end
        while (n_stim < NRAND) begin
            if ($urandom_range(0, 15) == 0) begin
                g = $urandom_range(1, 3);
                for (int i = 0; i < g; i++) begin
                    stim_clk[n_stim] = 2'($urandom);
                    stim_d0[n_stim]  = 2'($urandom);
                    stim_d1[n_stim]  = 2'($urandom);
                    n_stim++;
                end
            end
            cs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            for (int k = 0; k < 5; k++) begin
                stim_clk[n_stim] = (k == cs) ? 2'($urandom) : pat[k];
                stim_d0[n_stim]  = 2'($urandom);
                stim_d1[n_stim]  = 2'($urandom);
                n_stim++;
            end
        end
    endtask

    initial begin
        tbl[0]  = mk(8'hA5, 8'h3C, 4'h9, -1, 2'b00, 0, 0, 16'd0,
                     8'h00, 8'h00, 4'h0);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = mk(8'hA5, 8'h3C, 4'h9, -1, 2'b00, 1, 0, 16'd0,
                     8'h00, 8'h00, 4'h0);
        tbl[4]  = mk(8'hA5, 8'h3C, 4'h9, -1, 2'b00, 1, 1, 16'd0,
                     8'hA5, 8'h3C, 4'h9);
        tbl[5]  = mk(8'h5A, 8'hC3, 4'h6, -1, 2'b00, 1, 1, 16'd0,
                     8'h5A, 8'hC3, 4'h6);
        tbl[6]  = mk(8'h77, 8'h88, 4'hF, 2, 2'b00, 0, 0, 16'd1,
                     8'h5A, 8'hC3, 4'h6);
        tbl[7]  = mk(8'hA5, 8'h3C, 4'h9, -1, 2'b00, 0, 0, 16'd1,
                     8'h5A, 8'hC3, 4'h6);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = mk(8'hA5, 8'h3C, 4'h9, -1, 2'b00, 1, 0, 16'd1,
                     8'h5A, 8'hC3, 4'h6);
        tbl[11] = mk(8'h12, 8'h34, 4'hF, -1, 2'b00, 1, 1, 16'd1,
                     8'h12, 8'h34, 4'hF);

        // Reset state.
        rst = 1'b1;
        cyc(2'b11, 2'b11, 2'b11);
        cyc(2'b00, 2'b11, 2'b11);
        chk("rst_a", 64'(obs_a), 64'd0);
        chk("rst_b", 64'(obs_b), 64'd0);
        chk("rst_c", 64'(obs_c), 64'd0);
        rst = 1'b0;

        // Lock, data, induced loss and re-lock.
        cyc(2'b11, 2'b00, 2'b00);
        run_rows(0, 11);

        // Counter saturation from a preloaded near-full count.
        force dut_a.u_align.err_cnt_q = 16'hFFFE;
        frame(8'h11, 8'h22, 4'h3, -1, 2'b00, 1);
        release dut_a.u_align.err_cnt_q;
        frame(8'h11, 8'h22, 4'h3, 2, 2'b00, 0);
        chk("sat_inc_a", 64'(a_err), 64'hFFFF);
        chk("sat_inc_b", 64'(b_err), 64'd2);
        chk("sat_lock", 64'(a_lock), 64'd0);
        for (int i = 0; i < LOCKN; i++)
            frame(8'h11, 8'h22, 4'h3, -1, 2'b00, 0);
        chk("relock_a", 64'(a_lock), 64'd1);
        frame(8'h11, 8'h22, 4'h3, 0, 2'b11, 0);
        chk("sat_hold_a", 64'(a_err), 64'hFFFF);
        chk("sat_hold_b", 64'(b_err), 64'd3);

        // Re-lock, then reset in the middle of a locked frame.
        for (int i = 0; i < LOCKN; i++)
            frame(8'h66, 8'h99, 4'h5, -1, 2'b00, 0);
        frame(8'h66, 8'h99, 4'h5, -1, 2'b00, 1);
        chk("pre_rst_data", 64'({a_lock, a_btn, a_port, a_pow}),
            64'({1'b1, 8'h66, 8'h99, 4'h5}));
        cyc(pat[0], 2'b01, 2'b10);
        cyc(pat[1], 2'b01, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", 64'(obs_a), 64'd0);
        chk("async_rst_b", 64'(obs_b), 64'd0);
        cyc(pat[2], 2'b01, 2'b10);
        rst = 1'b0;

        // Restart mid-frame at slot 3 with junk data.
        cyc(pat[3], 2'($urandom), 2'($urandom));
        cyc(pat[4], 2'($urandom), 2'($urandom));
        run_rows(0, 4);

        // Randomized stream against the reference model.
        rst = 1'b1;
        cyc(2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        gen_random();
        run_model(0, n_stim);
        run_model(1, n_stim);
        for (int c = 0; c < n_stim; c++) begin
            cyc(stim_clk[c], stim_d0[c], stim_d1[c]);
            chk("rand_a", 64'(obs_a), 64'(exp_m[0][c]));
            chk("rand_b", 64'(obs_b), 64'(exp_m[0][c]));
            chk("rand_c", 64'(obs_c), 64'(exp_m[1][c]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
